pop_arbiter: RTL and testbench

Downstream drain stage for the dual-FIFO routing block. Watches the D0 and D1 FIFO empty flags and issues `D0_pop`/`D1_pop` under round-robin arbitration. Captures the popped words and merges them into a single registered output stream with valid/ready backpressure. Optional per-source delivered-word counters support debug and coverage.

---
 rtl/pop_arbiter.sv | 116 +++++++++++
 tb/tb_pop_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pop_arbiter.sv
// pop_arbiter: round-robin drain of the D0/D1 FIFOs into one registered
// valid/ready output stream. Define POP_ARB_COUNT_EN for delivered-word counters.
module pop_arbiter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [WIDTH-1:0] data_out_D0,
    input  logic [WIDTH-1:0] data_out_D1,
    input  logic             ready_out,
    output logic             D0_pop,
    output logic             D1_pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             src_out,
    output logic [CNT_W-1:0] count_D0,
    output logic [CNT_W-1:0] count_D1
);

    logic             r_inflight;
    logic             r_inflight_src;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic             r_last_grant;

    logic w_out_free;
    logic w_capture;
    logic w_pop_ok;
    logic w_gnt_any;
    logic w_gnt_src;

    assign w_out_free = !r_valid || ready_out;
    assign w_capture  = r_inflight && w_out_free;
    assign w_pop_ok   = !r_inflight || w_capture;

    // Round-robin grant; a stalled in-flight word or reset blocks any pop
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_src = 1'b0;
        if (w_pop_ok && !reset) begin
            if (!D0_empty && !D1_empty) begin
                w_gnt_any = 1'b1;
                w_gnt_src = !r_last_grant;
            end else if (!D0_empty) begin
                w_gnt_any = 1'b1;
                w_gnt_src = 1'b0;
            end else if (!D1_empty) begin
                w_gnt_any = 1'b1;
                w_gnt_src = 1'b1;
            end
        end
    end

    assign D0_pop    = w_gnt_any && !w_gnt_src;
    assign D1_pop    = w_gnt_any && w_gnt_src;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign src_out   = r_src;

    // Output register capture and in-flight / grant bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight     <= 1'b0;
            r_inflight_src <= 1'b0;
            r_valid        <= 1'b0;
            r_data         <= '0;
            r_src          <= 1'b0;
            r_last_grant   <= 1'b1;
        end else begin
            if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= r_inflight_src ? data_out_D1 : data_out_D0;
                r_src   <= r_inflight_src;
            end else if (r_valid && ready_out) begin
                r_valid <= 1'b0;
            end
            if (w_gnt_any) begin
                r_inflight     <= 1'b1;
                r_inflight_src <= w_gnt_src;
                r_last_grant   <= w_gnt_src;
            end else if (w_capture) begin
                r_inflight <= 1'b0;
            end
        end
    end

`ifdef POP_ARB_COUNT_EN
    logic             w_deliver;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    assign w_deliver = r_valid && ready_out;

    // Per-source delivered-word counters, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_deliver) begin
            if (r_src) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else       r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
    end

    assign count_D0 = r_cnt0;
    assign count_D1 = r_cnt1;
`else
    assign count_D0 = '0;
    assign count_D1 = '0;
`endif

endmodule

// File: tb/tb_pop_arbiter.sv
// tb_pop_arbiter: directed stimulus with FIFO models and a scoreboard
// monitor comparing every accepted output word against expected entries.
module tb_pop_arbiter;

    localparam int W  = 6;
    localparam int CW = 8;

    typedef struct packed {
        logic         src;
        logic [W-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          D0_empty = 1'b1;
    logic          D1_empty = 1'b1;
    logic [W-1:0]  data_out_D0 = '0;
    logic [W-1:0]  data_out_D1 = '0;
    logic          ready_out = 1'b1;
    logic          D0_pop, D1_pop;
    logic [W-1:0]  data_out;
    logic          valid_out, src_out;
    logic [CW-1:0] count_D0, count_D1;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    item_t        exp_q[$];
    item_t        e;
    int           n_vec = 0;
    int           n_err = 0;
    logic [CW-1:0] mc0 = '0;
    logic [CW-1:0] mc1 = '0;
    logic         s0 = 1'b0;
    logic         s1 = 1'b0;

    pop_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .ready_out(ready_out),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .count_D0(count_D0), .count_D1(count_D1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic upd();
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [W-1:0] d);
        item_t it;
        it.src  = src;
        it.data = d;
        if (src) q1.push_back(d);
        else     q0.push_back(d);
        exp_q.push_back(it);
        upd();
    endtask

    task automatic chk_counts(input string nm);
`ifdef POP_ARB_COUNT_EN
        chk({nm, "_cnt0"}, 32'(count_D0), 32'(mc0));
        chk({nm, "_cnt1"}, 32'(count_D1), 32'(mc1));
`else
        chk({nm, "_cnt0"}, 32'(count_D0), 32'd0);
        chk({nm, "_cnt1"}, 32'(count_D1), 32'd0);
`endif
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) begin
            chk({nm, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) step();
        chk({nm, "_idle_valid"}, 32'(valid_out), 32'd0);
        chk_counts(nm);
    endtask

    // FIFO model: sample pop strobes mid-cycle, deliver read data just after the edge
    always @(negedge clk) begin
        chk("pop_rules", 32'({D0_pop && D1_pop, D0_pop && D0_empty, D1_pop && D1_empty}), 32'd0);
        s0 = D0_pop;
        s1 = D1_pop;
    end

    always @(posedge clk) begin
        #1;
        if (s0 && q0.size() != 0) data_out_D0 = q0.pop_front();
        if (s1 && q1.size() != 0) data_out_D1 = q1.pop_front();
        s0 = 1'b0;
        s1 = 1'b0;
        upd();
    end

    // Scoreboard monitor: every accepted word must match the next expected entry
    always @(negedge clk) begin
        if (!reset && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got src %0d data %0h expected none", src_out, data_out);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", 32'({src_out, data_out}), 32'({e.src, e.data}));
                if (e.src) mc1 = mc1 + 1'b1;
                else       mc0 = mc0 + 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [2:0] t4_tab [5] = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b001};

    initial begin
        // Reset with both FIFOs non-empty
        push(1'b0, 6'd10);
        push(1'b1, 6'd20);
        repeat (2) step();
        @(negedge clk);
        chk("rst_pops", 32'({D0_pop, D1_pop}), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_src", 32'(src_out), 32'd0);
        chk("rst_cnt0", 32'(count_D0), 32'd0);
        chk("rst_cnt1", 32'(count_D1), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'({D0_pop, D1_pop}), 32'b10);
        drain("t1");

        // Single source, latency
        push(1'b0, 6'd3);
        push(1'b0, 6'd5);
        push(1'b0, 6'd9);
        @(negedge clk);
        chk("ss_c0", 32'({D0_pop, D1_pop, valid_out}), 32'b100);
        step();
        @(negedge clk);
        chk("ss_c1", 32'({D0_pop, D1_pop, valid_out}), 32'b100);
        step();
        @(negedge clk);
        chk("ss_c2", 32'({D0_pop, D1_pop, valid_out}), 32'b101);
        chk("ss_c2_word", 32'({src_out, data_out}), 32'({1'b0, 6'd3}));
        step();
        @(negedge clk);
        chk("ss_c3", 32'({D0_pop, D1_pop, valid_out}), 32'b001);
        drain("t2");

        // Alternation; D0 was granted last so D1 leads
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 6'(8'h21 + i));
            push(1'b0, 6'(8'h11 + i));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("alt_cycle", 32'({D0_pop, D1_pop, valid_out}),
                32'({i < 8 && i % 2 == 1, i < 8 && i % 2 == 0, i >= 2}));
            step();
        end
        drain("t3");

        // Backpressure: ready low for 5 cycles
        ready_out = 1'b0;
        push(1'b1, 6'd41);
        push(1'b0, 6'd31);
        push(1'b1, 6'd42);
        push(1'b0, 6'd32);
        push(1'b0, 6'd33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cycle", 32'({D0_pop, D1_pop, valid_out}), 32'(t4_tab[i]));
            if (i >= 2) chk("bp_hold", 32'({src_out, data_out}), 32'({1'b1, 6'd41}));
            step();
        end
        ready_out = 1'b1;
        drain("t4");

        // Reset while a word is in flight; that word is lost
        q0.push_back(6'd51);
        upd();
        push(1'b0, 6'd52);
        push(1'b0, 6'd53);
        step();
        reset = 1'b1;
        mc0 = '0;
        mc1 = '0;
        @(negedge clk);
        chk("mrst_pops", 32'({D0_pop, D1_pop}), 32'd0);
        chk("mrst_valid", 32'(valid_out), 32'd0);
        chk("mrst_cnt", 32'({count_D0, count_D1}), 32'd0);
        step();
        reset = 1'b0;
        drain("t5");

        // 256 words from D1: counter wraps back
        for (int i = 0; i < 256; i++) push(1'b1, 6'(i * 7));
        drain("t6");
`ifdef POP_ARB_COUNT_EN
        chk("wrap_cnt0", 32'(count_D0), 32'd2);
        chk("wrap_cnt1", 32'(count_D1), 32'd0);
`endif

        chk("exp_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
